// File: rtl/apb_selftest_requester.sv
// APB requester self-test: writes a deterministic pattern to NUM_WORDS
// completer registers, reads them back, and reports sticky passed/failed.
module apb_selftest_requester #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [31:0] SEED      = 32'hA5A5_0001,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              passed,
  output logic              failed
);

  localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [DATA_W-1:0] SEED_D = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STEP   = DATA_W'(32'h0101_0101);
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(NUM_WORDS - 1);
  localparam logic [TCNT_W-1:0] TC_LIM = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                phase_rd, phase_rd_n;
  logic [TCNT_W-1:0]   tcnt, tcnt_n;
  logic                pwrite_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [DATA_W-1:0]   pwdata_n;
  logic                passed_n, failed_n;

  function automatic logic [DATA_W-1:0] pat(input logic [IDX_W-1:0] j);
    return SEED_D + DATA_W'(j) * STEP;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] j);
    return ADDR_W'({j, 2'b00});
  endfunction

  assign psel    = (state == S_SETUP) || (state == S_ACCESS);
  assign penable = (state == S_ACCESS);

  // State and registered APB request fields; reset clears every output at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      phase_rd <= 1'b0;
      tcnt     <= '0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      passed   <= 1'b0;
      failed   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      phase_rd <= phase_rd_n;
      tcnt     <= tcnt_n;
      pwrite   <= pwrite_n;
      paddr    <= paddr_n;
      pwdata   <= pwdata_n;
      passed   <= passed_n;
      failed   <= failed_n;
    end
  end

  // Next-state, transfer sequencing, result and timeout decisions
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    phase_rd_n = phase_rd;
    tcnt_n     = tcnt;
    pwrite_n   = pwrite;
    paddr_n    = paddr;
    pwdata_n   = pwdata;
    passed_n   = passed;
    failed_n   = failed;

    unique case (state)
      S_IDLE: begin
        state_n    = S_SETUP;
        idx_n      = '0;
        phase_rd_n = 1'b0;
        tcnt_n     = '0;
        pwrite_n   = 1'b1;
        paddr_n    = word_addr('0);
        pwdata_n   = pat('0);
      end

      S_SETUP: begin
        state_n = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready) begin
          if (pslverr || (phase_rd && (prdata != pat(idx)))) begin
            failed_n = 1'b1;
            state_n  = S_DONE;
          end else if (idx == LAST && !phase_rd) begin
            state_n    = S_SETUP;
            idx_n      = '0;
            phase_rd_n = 1'b1;
            tcnt_n     = '0;
            pwrite_n   = 1'b0;
            paddr_n    = word_addr('0);
            pwdata_n   = '0;
          end else if (idx == LAST) begin
            passed_n = 1'b1;
            state_n  = S_DONE;
          end else begin
            state_n  = S_SETUP;
            idx_n    = idx + IDX_W'(1);
            tcnt_n   = '0;
            pwrite_n = !phase_rd;
            paddr_n  = word_addr(idx + IDX_W'(1));
            pwdata_n = phase_rd ? '0 : pat(idx + IDX_W'(1));
          end
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
          // Fail on the same edge the counter reaches TIMEOUT
          if (tcnt == TC_LIM) begin
            failed_n = 1'b1;
            state_n  = S_DONE;
          end
        end
        if (state_n == S_DONE) begin
          pwrite_n = 1'b0;
          paddr_n  = '0;
          pwdata_n = '0;
        end
      end

      S_DONE: begin
        state_n = S_DONE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_selftest_requester.sv
// Directed bench for apb_selftest_requester with a memory-backed APB completer model.
module tb_apb_selftest_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, passed, failed;

  int checks = 0;
  int errors = 0;

  // Completer behaviour knobs
  int unsigned nwait = 0;
  logic        stuck = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [2:0]  bad_idx = 3'd0;
  logic        err_en = 1'b0;
  logic [2:0]  err_idx = 3'd0;

  logic [31:0] mem [0:7];
  int unsigned wcnt;
  int          xfer_cnt, wait_cyc, stab_err;
  logic [7:0]  log_addr [0:15];
  logic [31:0] log_data [0:15];
  logic        log_wr   [0:15];
  logic [7:0]  s_addr;
  logic [31:0] s_data;
  logic        s_wr, prev_wait;

  logic [31:0] exp_w [0:7] = '{32'hA5A5_0001, 32'hA6A6_0102, 32'hA7A7_0203, 32'hA8A8_0304,
                               32'hA9A9_0405, 32'hAAAA_0506, 32'hABAB_0607, 32'hACAC_0708};

  apb_selftest_requester #(
    .ADDR_W(8),
    .DATA_W(32),
    .NUM_WORDS(8),
    .SEED(32'hA5A5_0001),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .passed(passed),
    .failed(failed)
  );

  always #5 clk = ~clk;

  assign pready  = !stuck && (wcnt >= nwait);
  assign pslverr = err_en && pwrite && (paddr[4:2] == err_idx);

  always_comb begin
    prdata = mem[paddr[4:2]];
    if (corrupt_en && !pwrite && (paddr[4:2] == bad_idx)) prdata = prdata ^ 32'h1;
  end

  // Completer memory, wait-state counter and transfer log
  always @(posedge clk) begin
    if (!reset) begin
      wcnt     <= 0;
      xfer_cnt <= 0;
      wait_cyc <= 0;
    end else if (psel && penable) begin
      if (pready) begin
        wcnt <= 0;
        if (xfer_cnt < 16) begin
          log_addr[xfer_cnt] <= paddr;
          log_data[xfer_cnt] <= pwdata;
          log_wr[xfer_cnt]   <= pwrite;
        end
        xfer_cnt <= xfer_cnt + 1;
        if (pwrite) mem[paddr[4:2]] <= pwdata;
      end else begin
        wcnt     <= wcnt + 1;
        wait_cyc <= wait_cyc + 1;
      end
    end
  end

  // Request stability and penable hold across wait states
  always @(negedge clk) begin
    if (!reset) begin
      stab_err  <= 0;
      prev_wait <= 1'b0;
    end else begin
      if (psel && !penable) begin
        s_addr <= paddr;
        s_data <= pwdata;
        s_wr   <= pwrite;
      end else if (psel && penable && (paddr !== s_addr || pwdata !== s_data || pwrite !== s_wr)) begin
        stab_err <= stab_err + 1;
      end else if (prev_wait && !(psel && penable)) begin
        stab_err <= stab_err + 1;
      end
      prev_wait <= psel && penable && !pready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_ideal();
    nwait = 0; stuck = 1'b0; corrupt_en = 1'b0; err_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite});
    end
    checks++;
    if (paddr !== 8'h00 || pwdata !== 32'h0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h expected 00/00000000", paddr, pwdata);
    end
    checks++;
    if ({passed, failed} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {passed, failed});
    end
  endtask

  task automatic test_ideal();
    set_ideal();
    do_reset();
    for (int e = 0; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 8'h00 || pwdata !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL ideal_edge0: got sel/en/wr=%b addr=%h data=%h expected 101 00 a5a50001",
                   {psel, penable, pwrite}, paddr, pwdata);
        end
      end
      if (e == 31) begin
        checks++;
        if (passed !== 1'b0) begin errors++; $display("FAIL ideal_early_pass: got %b expected 0", passed); end
      end
      if (e == 32) begin
        checks++;
        if ({passed, failed} !== 2'b10) begin
          errors++; $display("FAIL ideal_pass_edge32: got %b expected 10", {passed, failed});
        end
      end
    end
    checks++;
    if (xfer_cnt !== 16) begin errors++; $display("FAIL ideal_xfers: got %0d expected 16", xfer_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_addr[i] !== 8'(i * 4) || log_data[i] !== exp_w[i] || log_wr[i] !== 1'b1) begin
        errors++;
        $display("FAIL ideal_write%0d: got addr=%h data=%h wr=%b expected %h %h 1",
                 i, log_addr[i], log_data[i], log_wr[i], 8'(i * 4), exp_w[i]);
      end
      checks++;
      if (log_addr[8+i] !== 8'(i * 4) || log_data[8+i] !== 32'h0 || log_wr[8+i] !== 1'b0) begin
        errors++;
        $display("FAIL ideal_read%0d: got addr=%h data=%h wr=%b expected %h 00000000 0",
                 i, log_addr[8+i], log_data[8+i], log_wr[8+i], 8'(i * 4));
      end
    end
    repeat (4) @(posedge clk); #1;
    checks++;
    if ({psel, penable, pwrite} !== 3'b000 || paddr !== 8'h00 || pwdata !== 32'h0 || passed !== 1'b1) begin
      errors++;
      $display("FAIL ideal_done_outputs: got ctrl=%b addr=%h data=%h passed=%b expected 000 00 0 1",
               {psel, penable, pwrite}, paddr, pwdata, passed);
    end
  endtask

  task automatic test_waits();
    set_ideal();
    nwait = 2;
    do_reset();
    for (int e = 0; e <= 64; e++) begin
      @(posedge clk); #1;
      if (e == 63) begin
        checks++;
        if (passed !== 1'b0) begin errors++; $display("FAIL waits_early_pass: got %b expected 0", passed); end
      end
      if (e == 64) begin
        checks++;
        if ({passed, failed} !== 2'b10) begin
          errors++; $display("FAIL waits_pass_edge64: got %b expected 10", {passed, failed});
        end
      end
    end
    checks++;
    if (wait_cyc !== 32) begin errors++; $display("FAIL waits_count: got %0d expected 32", wait_cyc); end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL waits_stability: got %0d violations expected 0", stab_err); end
    nwait = 0;
  endtask

  task automatic test_corrupt();
    set_ideal();
    corrupt_en = 1'b1;
    bad_idx = 3'd5;
    do_reset();
    for (int e = 0; e <= 28; e++) begin
      @(posedge clk); #1;
      if (e == 27) begin
        checks++;
        if (failed !== 1'b0) begin errors++; $display("FAIL corrupt_early_fail: got %b expected 0", failed); end
      end
      if (e == 28) begin
        checks++;
        if ({passed, failed} !== 2'b01) begin
          errors++; $display("FAIL corrupt_fail_edge28: got %b expected 01", {passed, failed});
        end
      end
    end
    repeat (6) @(posedge clk); #1;
    checks++;
    if (xfer_cnt !== 14 || psel !== 1'b0 || passed !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_stop: got xfers=%0d psel=%b passed=%b expected 14 0 0", xfer_cnt, psel, passed);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_slverr();
    logic sel_seen;
    set_ideal();
    err_en = 1'b1;
    err_idx = 3'd2;
    do_reset();
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 5) begin
        checks++;
        if (failed !== 1'b0) begin errors++; $display("FAIL slverr_early_fail: got %b expected 0", failed); end
      end
      if (e == 6) begin
        checks++;
        if ({passed, failed} !== 2'b01) begin
          errors++; $display("FAIL slverr_fail_edge6: got %b expected 01", {passed, failed});
        end
      end
    end
    sel_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (psel !== 1'b0) sel_seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (sel_seen !== 1'b0 || xfer_cnt !== 3) begin
      errors++; $display("FAIL slverr_idle: got psel_seen=%b xfers=%0d expected 0 3", sel_seen, xfer_cnt);
    end
    err_en = 1'b0;
  endtask

  task automatic test_timeout();
    set_ideal();
    stuck = 1'b1;
    do_reset();
    for (int e = 0; e <= 17; e++) begin
      @(posedge clk); #1;
      if (e == 16) begin
        checks++;
        if ({psel, penable, failed} !== 3'b110) begin
          errors++; $display("FAIL timeout_edge16: got sel/en/failed=%b expected 110", {psel, penable, failed});
        end
      end
      if (e == 17) begin
        checks++;
        if ({psel, penable, passed, failed} !== 4'b0001) begin
          errors++;
          $display("FAIL timeout_edge17: got sel/en/passed/failed=%b expected 0001", {psel, penable, passed, failed});
        end
      end
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_ideal();
    do_reset();
    for (int e = 0; e <= 22; e++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({psel, penable, pwrite} !== 3'b100 || paddr !== 8'h0C) begin
      errors++;
      $display("FAIL midreset_setup_rd3: got ctrl=%b addr=%h expected 100 0c", {psel, penable, pwrite}, paddr);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, passed, failed} !== 5'b0 || paddr !== 8'h00 || pwdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: got ctrl/flags=%b addr=%h data=%h expected 00000 00 0",
               {psel, penable, pwrite, passed, failed}, paddr, pwdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 8'h00 || pwdata !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL midreset_restart: got ctrl=%b addr=%h data=%h expected 101 00 a5a50001",
                   {psel, penable, pwrite}, paddr, pwdata);
        end
      end
      if (e == 31) begin
        checks++;
        if (passed !== 1'b0) begin errors++; $display("FAIL midreset_early_pass: got %b expected 0", passed); end
      end
      if (e == 32) begin
        checks++;
        if ({passed, failed} !== 2'b10) begin
          errors++; $display("FAIL midreset_pass: got %b expected 10", {passed, failed});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_waits();
    test_corrupt();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
